vga_code_display: RTL and testbench
===================================

// Module: vga_code_display
// PURPOSE
// Downstream consumer of the 24-bit two-digit colour code (code[23:12] = tens colour,
// code[11:0] = ones colour, each 12-bit RGB 4:4:4). Generates 640x480@60 VGA timing
// from the system clock and paints the left half of the screen in the tens colour
// and the right half in the ones colour. The code is sampled once per frame so the
// picture never tears. Sits between the colour-code stage and the board VGA pins.
// PARAMETERS
// CLK_DIV    2    system clocks per pixel (>=1); 2 gives 25 MHz pixels from 50 MHz
// H_VISIBLE  640  visible pixels per line
// H_FRONT    16   horizontal front porch, pixels
// H_SYNC     96   horizontal sync width, pixels
// H_BACK     48   horizontal back porch, pixels
// V_VISIBLE  480  visible lines per frame
// V_FRONT    10   vertical front porch, lines
// V_SYNC     2    vertical sync width, lines
// V_BACK     33   vertical back porch, lines
// PORTS
// clk          in   1   system clock, all logic on rising edge
// rst          in   1   synchronous, active-high reset
// code         in   24  {tens RGB, ones RGB} from the colour-code stage
// hsync        out  1   horizontal sync, active low
// vsync        out  1   vertical sync, active low
// red          out  4   red channel
// green        out  4   green channel
// blue         out  4   blue channel
// frame_start  out  1   one-clk pulse when counters wrap to pixel (0,0)
// BEHAVIOUR
// - Reset (sync, active-high): div_cnt=0, h_cnt=0, v_cnt=0, code_q=0, hsync=1,
//   vsync=1, red/green/blue=0, frame_start=0. Reset mid-frame restarts at (0,0) in
//   the first cycle after rst deasserts; no frame_start pulse is produced by reset.
// - Pixel tick: div_cnt counts 0..CLK_DIV-1; pix_tick=1 when div_cnt==CLK_DIV-1.
//   CLK_DIV=1 gives pix_tick every cycle.
// - H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//   h_cnt/v_cnt are at least 10 bits wide and sized to hold TOTAL-1.
// - On pix_tick: h_cnt++; at H_TOTAL-1, h_cnt->0 and v_cnt++; v_cnt wraps
//   V_TOTAL-1->0 on the same tick that h_cnt wraps.
// - Frame latch: on pix_tick with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1,
//   code_q<=code. frame_start is 1 for exactly the following clk cycle.
//   code changes mid-frame have no visible effect until the next frame.
//   The first frame after reset is black because code_q=0.
// - Outputs are registered and updated only on pix_tick, from the current counters.
//   Outputs therefore lag the counters by one pixel, uniformly across the frame.
//   Between ticks, outputs hold their values.
//   hsync=0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
//   vsync=0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
//   Visible area is h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
//   Inside it: h_cnt<H_VISIBLE/2 -> {red,green,blue}=code_q[23:12];
//   otherwise -> code_q[11:0].
//   Outside it: red/green/blue=0.
// TESTING
// 1 Reset, CLK_DIV=2 -> hsync period 1600 clk, low 192 clk;
//   vsync period 840000 clk, low 3200 clk.
// 2 code=24'hF00_0F0 held two frames -> 2nd frame: visible h 0..319 RGB=F,0,0;
//   h 320..639 RGB=0,F,0; all blanking RGB=0.
// 3 code 24'hF00_0F0 -> 24'h00F_FFF at line 200 -> rest of frame unchanged;
//   next frame: left 0,0,F, right F,F,F.
// 4 rst pulsed 1 cycle at line 300 -> outputs at reset values next cycle;
//   first frame_start exactly 800*525*CLK_DIV clk after rst deasserts.
// 5 CLK_DIV=1 -> pix_tick every clk; hsync period 800 clk, low 96 clk.
// 6 Free run 3 frames -> exactly one frame_start per frame, 1 clk wide;
//   code_q changes only on that boundary.

Source files
------------

// File: rtl/vga_code_display.sv
`default_nettype none
// ============================================================================
//  Module   : vga_code_display
//  Purpose  : VGA timing generator that shows the two-digit colour code.
//             The left half of the visible area is painted in the tens colour
//             (code[23:12]) and the right half in the ones colour (code[11:0]).
//             The code is captured once per frame so the picture never tears.
//  Ports    : clk          system clock, rising edge
//             rst          synchronous active-high reset
//             code[23:0]   {tens RGB444, ones RGB444}
//             hsync        horizontal sync, active low
//             vsync        vertical sync, active low
//             red/green/blue[3:0]  colour channels
//             frame_start  one-clock pulse when counters wrap to pixel (0,0)
//  Revision : 1.0  initial release
// ============================================================================
module vga_code_display #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] code,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam int c_h_total   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_max_total = (c_h_total > c_v_total) ? c_h_total : c_v_total;
    localparam int c_cnt_w     = ($clog2(c_max_total) > 10) ? $clog2(c_max_total) : 10;
    localparam int c_div_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_cnt_w-1:0] c_h_last     = c_cnt_w'(c_h_total - 1);
    localparam logic [c_cnt_w-1:0] c_v_last     = c_cnt_w'(c_v_total - 1);
    localparam logic [c_cnt_w-1:0] c_h_vis      = c_cnt_w'(H_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_h_half     = c_cnt_w'(H_VISIBLE / 2);
    localparam logic [c_cnt_w-1:0] c_v_vis      = c_cnt_w'(V_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_hs_start   = c_cnt_w'(H_VISIBLE + H_FRONT);
    localparam logic [c_cnt_w-1:0] c_hs_end     = c_cnt_w'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_cnt_w-1:0] c_vs_start   = c_cnt_w'(V_VISIBLE + V_FRONT);
    localparam logic [c_cnt_w-1:0] c_vs_end     = c_cnt_w'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               w_pix_tick;
    logic [c_cnt_w-1:0] r_h_cnt;
    logic [c_cnt_w-1:0] r_v_cnt;
    logic [23:0]        r_code_q;
    logic               w_h_wrap;
    logic               w_frame_wrap;
    logic               w_hsync_n;
    logic               w_vsync_n;
    logic [11:0]        w_rgb;

    // ------------------------------------------------------------------
    // Pixel clock enable
    // ------------------------------------------------------------------
    generate
        if (CLK_DIV > 1) begin : g_div
            logic [c_div_w-1:0] r_div_cnt;
            localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == c_div_last) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end

            assign w_pix_tick = (r_div_cnt == c_div_last);
        end else begin : g_no_div
            assign w_pix_tick = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters and per-frame code capture
    // ------------------------------------------------------------------
    assign w_h_wrap     = (r_h_cnt == c_h_last);
    assign w_frame_wrap = w_h_wrap && (r_v_cnt == c_v_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_code_q <= '0;
        end else if (w_pix_tick) begin
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
            if (w_frame_wrap) begin
                r_code_q <= code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the current counters. Registering it below makes
    // every output lag the counters by exactly one pixel. The last pixel of
    // a frame is always blanking, so the code update on that same tick can
    // never show up in the decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_hsync_n = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
        w_vsync_n = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
        w_rgb     = 12'h000;
        if ((r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis)) begin
            w_rgb = (r_h_cnt < c_h_half) ? r_code_q[23:12] : r_code_q[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            // Pulse lasts one system clock even when ticks are CLK_DIV apart.
            frame_start <= w_pix_tick && w_frame_wrap;
            if (w_pix_tick) begin
                hsync <= w_hsync_n;
                vsync <= w_vsync_n;
                red   <= w_rgb[11:8];
                green <= w_rgb[7:4];
                blue  <= w_rgb[3:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_code_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_code_display
//  Purpose  : Self-checking bench for vga_code_display. Two instances share
//             stimulus: one with CLK_DIV=2, one with CLK_DIV=1, both using a
//             reduced raster so several whole frames fit in a short run.
//             Expected outputs come from a pixel-position model: the number
//             of clocks since reset gives the tick count, which gives the
//             raster position, which gives sync and colour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_code_display;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DIV0 = 2;
    localparam int DIV1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] code;

    logic        hsync0, vsync0, fs0, hsync1, vsync1, fs1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;

    int tests  = 0;
    int errors = 0;
    bit armed  = 0;

    always #5 clk = ~clk;

    vga_code_display #(
        .CLK_DIV(DIV0), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut_div2 (
        .clk(clk), .rst(rst), .code(code),
        .hsync(hsync0), .vsync(vsync0), .red(r0), .green(g0), .blue(b0),
        .frame_start(fs0)
    );

    vga_code_display #(
        .CLK_DIV(DIV1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut_div1 (
        .clk(clk), .rst(rst), .code(code),
        .hsync(hsync1), .vsync(vsync1), .red(r1), .green(g1), .blue(b1),
        .frame_start(fs1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed as {hsync, vsync, rgb[11:0], frame_start}
    function automatic logic [14:0] pixel_out(input int p, input logic [23:0] q);
        int          h;
        int          v;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        h   = p % HT;
        v   = p / HT;
        hs  = !(h >= HV + HF && h < HV + HF + HS);
        vs  = !(v >= VV + VF && v < VV + VF + VS);
        rgb = 12'h000;
        if (h < HV && v < VV) rgb = (h < HV / 2) ? q[23:12] : q[11:0];
        return {hs, vs, rgb, 1'b0};
    endfunction

    // Reference model, one slot per instance
    int          n    [2];
    logic [23:0] mq   [2];
    logic [14:0] expv [2];
    int          divs [2] = '{DIV0, DIV1};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                n[d]    = 0;
                mq[d]   = 24'h0;
                expv[d] = {1'b1, 1'b1, 12'h000, 1'b0};
            end else begin
                n[d]++;
                if (n[d] % divs[d] == 0) begin
                    int p;
                    // raster position the counters held just before this tick
                    p = (n[d] / divs[d] - 1) % FRAME;
                    expv[d] = pixel_out(p, mq[d]);
                    if (p == FRAME - 1) begin
                        expv[d][0] = 1'b1;
                        mq[d]      = code;
                    end
                end else begin
                    expv[d][0] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("div2_pixel", {17'h0, hsync0, vsync0, r0, g0, b0, fs0}, {17'h0, expv[0]});
            check("div1_pixel", {17'h0, hsync1, vsync1, r1, g1, b1, fs1}, {17'h0, expv[1]});
        end
    end

    // Release reset and measure latency to the first frame_start and the
    // number of pulses over the next 2*FRAME*DIV0 clocks.
    task automatic release_and_measure(input string tag);
        int lat0, lat1, cnt0, cnt1;
        lat0 = 0; lat1 = 0; cnt0 = 0; cnt1 = 0;
        rst = 1'b0;
        for (int c = 1; c <= 2 * FRAME * DIV0; c++) begin
            @(negedge clk);
            if (fs0) begin cnt0++; if (lat0 == 0) lat0 = c; end
            if (fs1) begin cnt1++; if (lat1 == 0) lat1 = c; end
        end
        check({tag, "_lat_div2"}, lat0, FRAME * DIV0);
        check({tag, "_lat_div1"}, lat1, FRAME * DIV1);
        check({tag, "_cnt_div2"}, cnt0, 2);
        check({tag, "_cnt_div1"}, cnt1, 2 * DIV0);
    endtask

    initial begin
        rst  = 1'b1;
        code = 24'h000000;
        @(negedge clk);
        armed = 1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {hsync0, vsync0, r0, g0, b0, fs0}, {1'b1, 1'b1, 12'h000, 1'b0});

        // Red/green held across frames; first frame black
        code = 24'hF00_0F0;
        release_and_measure("boot");
        repeat (FRAME * DIV0) @(negedge clk);

        // Mid-frame code change: wait for a frame start, move to line 5
        for (int c = 0; c < 2 * FRAME * DIV0 && !fs0; c++) @(negedge clk);
        repeat (5 * HT * DIV0) @(negedge clk);
        code = 24'h00F_FFF;
        repeat (2 * FRAME * DIV0) @(negedge clk);

        // Random code changes at random moments
        repeat (4 * FRAME * DIV0) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) code = $urandom;
        end

        // One-cycle reset pulse at a random point mid-frame
        repeat ($urandom_range(1, FRAME * DIV0)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_div2", {hsync0, vsync0, r0, g0, b0, fs0}, {1'b1, 1'b1, 12'h000, 1'b0});
        check("midrst_div1", {hsync1, vsync1, r1, g1, b1, fs1}, {1'b1, 1'b1, 12'h000, 1'b0});
        code = $urandom;
        release_and_measure("midrst");

        repeat (2 * FRAME * DIV0) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) code = $urandom;
        end

        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
